// File: rtl/pid_pkg.sv
// Shared widths and helpers for the PID-to-PWM output stage.
// Optional dead-time insertion is enabled with PID_PWM_DEADTIME_EN.
package pid_pkg;

    localparam int unsigned AW_DEF = 1;
    localparam int unsigned OW_DEF = 12;
    localparam int unsigned DT_DEF = 16;

    // |v| clamped to 2^(w-1)-1 so the most negative code still fits.
    function automatic logic [31:0] sat_mag(
        input logic signed [31:0] v,
        input int unsigned        w
    );
        logic [31:0] lim;
        logic [31:0] mag;
        lim = (32'd1 << (w - 1)) - 32'd1;
        mag = v[31] ? 32'(-v) : 32'(v);
        if (mag > lim) begin
            mag = lim;
        end
        return mag;
    endfunction

endpackage

// File: rtl/pid_pwm_chan.sv
// One PWM channel: shadow/active magnitude and sign, comparator,
// optional dead-time counter (PID_PWM_DEADTIME_EN).
module pid_pwm_chan
    import pid_pkg::*;
#(
    parameter int unsigned ow = OW_DEF,
    parameter int unsigned dt = DT_DEF
) (
    input  logic                 clk_pid,
    input  logic                 reset,
    input  logic                 ld,
    input  logic signed [ow-1:0] m_k_in,
    input  logic [ow-2:0]        cnt,
    input  logic                 wrap,
    output logic                 pwm,
    output logic                 dir
);

    localparam int unsigned MW = ow - 1;

    logic [MW-1:0] sh_mag_q, sh_mag_d;
    logic [MW-1:0] act_mag_q, act_mag_d;
    logic          sh_sign_q, sh_sign_d;
    logic          act_sign_q, act_sign_d;
    logic          pwm_q, pwm_d;
    logic          dir_q, dir_d;

    always_comb begin
        sh_mag_d   = sh_mag_q;
        sh_sign_d  = sh_sign_q;
        act_mag_d  = act_mag_q;
        act_sign_d = act_sign_q;
        if (ld) begin
            sh_mag_d  = MW'(sat_mag(32'(m_k_in), ow));
            sh_sign_d = m_k_in[ow-1];
        end
        // Active values change only at the period boundary.
        if (wrap) begin
            act_mag_d  = sh_mag_q;
            act_sign_d = sh_sign_q;
        end
        dir_d = act_sign_q;
    end

`ifdef PID_PWM_DEADTIME_EN
    logic [7:0] dt_cnt_q, dt_cnt_d;

    always_comb begin
        dt_cnt_d = dt_cnt_q;
        if (wrap && (sh_sign_q != act_sign_q)) begin
            dt_cnt_d = 8'(dt);
        end else if (dt_cnt_q != 8'd0) begin
            dt_cnt_d = dt_cnt_q - 8'd1;
        end
        pwm_d = (cnt < act_mag_q) && (dt_cnt_q == 8'd0);
    end

    always_ff @(posedge clk_pid) begin
        if (reset) begin
            dt_cnt_q <= 8'd0;
        end else begin
            dt_cnt_q <= dt_cnt_d;
        end
    end
`else
    always_comb begin
        pwm_d = cnt < act_mag_q;
    end
`endif

    always_ff @(posedge clk_pid) begin
        if (reset) begin
            sh_mag_q   <= '0;
            sh_sign_q  <= 1'b0;
            act_mag_q  <= '0;
            act_sign_q <= 1'b0;
            pwm_q      <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            sh_mag_q   <= sh_mag_d;
            sh_sign_q  <= sh_sign_d;
            act_mag_q  <= act_mag_d;
            act_sign_q <= act_sign_d;
            pwm_q      <= pwm_d;
            dir_q      <= dir_d;
        end
    end

    assign pwm = pwm_q;
    assign dir = dir_q;

endmodule

// File: rtl/pid_pwm_out.sv
// PID motor-power to per-channel PWM/direction outputs.
// Build with PID_PWM_DEADTIME_EN to insert dead-time on reversal.
module pid_pwm_out
    import pid_pkg::*;
#(
    parameter int unsigned aw = AW_DEF,
    parameter int unsigned ow = OW_DEF,
    parameter int unsigned dt = DT_DEF
) (
    input  logic                  clk_pid,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [aw-1:0]         a,
    input  logic signed [ow-1:0]  m_k_in,
    output logic [(1<<aw)-1:0]    pwm_out,
    output logic [(1<<aw)-1:0]    dir_out,
    output logic                  upd
);

    localparam int unsigned AN = 1 << aw;
    localparam int unsigned CW = ow - 1;

    logic          ce_d_q, ce_d_d;
    logic          upd_q, upd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          capture;
    logic          wrap;
    logic [AN-1:0] ld;

    always_comb begin
        capture = ce && !ce_d_q;
        ce_d_d  = ce;
        upd_d   = capture;
        wrap    = (cnt_q == {CW{1'b1}});
        cnt_d   = cnt_q + CW'(1);
        for (int i = 0; i < AN; i++) begin
            ld[i] = capture && (a == aw'(i));
        end
    end

    always_ff @(posedge clk_pid) begin
        if (reset) begin
            ce_d_q <= 1'b0;
            upd_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ce_d_q <= ce_d_d;
            upd_q  <= upd_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar i = 0; i < AN; i++) begin : g_chan
        pid_pwm_chan #(
            .ow (ow),
            .dt (dt)
        ) u_chan (
            .clk_pid (clk_pid),
            .reset   (reset),
            .ld      (ld[i]),
            .m_k_in  (m_k_in),
            .cnt     (cnt_q),
            .wrap    (wrap),
            .pwm     (pwm_out[i]),
            .dir     (dir_out[i])
        );
    end

    assign upd = upd_q;

endmodule
